// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: control, external pixel source
// and aligned raster outputs of the timing generator.
interface video_timing_gen_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [7:0]  pix_r;
  logic [7:0]  pix_g;
  logic [7:0]  pix_b;
  logic        pix_req;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  red;
  logic [7:0]  green;
  logic [7:0]  blue;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  enable, pattern_sel,
    input  pix_r, pix_g, pix_b,
    output pix_req, x, y,
    output hsync, vsync, de,
    output red, green, blue,
    output frame_start, frame_cnt
  );

  modport slave (
    output enable, pattern_sel,
    output pix_r, pix_g, pix_b,
    input  pix_req, x, y,
    input  hsync, vsync, de,
    input  red, green, blue,
    input  frame_start, frame_cnt
  );
endinterface

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, 2-stage aligned timing and RGB.
// VTG_TEST_PATTERN_EN compiles in bars/grid/ramp test patterns.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b1,
  parameter bit V_POL    = 1'b1
) (
  input  logic pixclk,
  input  logic reset,
  video_timing_gen_if.master vif
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HA    = 10'(H_ACTIVE);
  localparam logic [9:0] HS_B  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_E  = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] HT_M1 = 10'(H_TOTAL - 1);
  localparam logic [9:0] VA    = 10'(V_ACTIVE);
  localparam logic [9:0] VS_B  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_E  = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] VT_M1 = 10'(V_TOTAL - 1);

  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic        x_last;
  logic        y_last;
  logic        act_c;
  logic        hs_c;
  logic        vs_c;
  logic        first_c;

  logic        s1_act;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_first;

  logic        de_q;
  logic        hs_q;
  logic        vs_q;
  logic        fs_q;
  logic [15:0] fc_q;
  logic [15:0] fc_nxt;
  logic [7:0]  r_q;
  logic [7:0]  g_q;
  logic [7:0]  b_q;

  assign x_last  = (x_q == HT_M1);
  assign y_last  = (y_q == VT_M1);
  assign act_c   = (x_q < HA) && (y_q < VA);
  assign hs_c    = (x_q >= HS_B) && (x_q < HS_E);
  assign vs_c    = (y_q >= VS_B) && (y_q < VS_E);
  assign first_c = (x_q == '0) && (y_q == '0);

  assign vif.x           = x_q;
  assign vif.y           = y_q;
  assign vif.pix_req     = act_c;
  assign vif.de          = de_q;
  assign vif.hsync       = hs_q;
  assign vif.vsync       = vs_q;
  assign vif.frame_start = fs_q;
  assign vif.frame_cnt   = fc_q;
  assign vif.red         = r_q;
  assign vif.green       = g_q;
  assign vif.blue        = b_q;

  // raster counters: x wraps per line, y advances at line end
  always_ff @(posedge pixclk) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (vif.enable) begin
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + 10'd1;
      end else begin
        x_q <= x_q + 10'd1;
      end
    end
  end

`ifdef VTG_TEST_PATTERN_EN
  localparam logic [9:0] BW_M1 = 10'(H_ACTIVE / 8 - 1);

  logic [1:0] pat_q;
  logic [9:0] bar_px;
  logic [2:0] bar_idx;
  logic       grid_c;
  logic       ext_c;
  logic       ramp_c;
  logic [7:0] pr_c;
  logic [7:0] pg_c;
  logic [7:0] pb_c;
  logic       s1_ext;
  logic       s1_ramp;
  logic [7:0] s1_r;
  logic [7:0] s1_g;
  logic [7:0] s1_b;

  assign grid_c = (x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0);

  // pattern latched at the frame seam; bar index tracks x by width
  always_ff @(posedge pixclk) begin
    if (reset) begin
      pat_q   <= '0;
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (vif.enable) begin
      if (x_last && y_last)
        pat_q <= vif.pattern_sel;
      if (x_last) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BW_M1) begin
        bar_px <= '0;
        if (bar_idx != 3'd7)
          bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + 10'd1;
      end
    end
  end

  // pattern colour for the current coordinate
  always_comb begin
    pr_c   = '0;
    pg_c   = '0;
    pb_c   = '0;
    ext_c  = 1'b0;
    ramp_c = 1'b0;
    unique case (1'b1)
      (pat_q == 2'd0): begin
        pr_c = {8{~bar_idx[1]}};
        pg_c = {8{~bar_idx[2]}};
        pb_c = {8{~bar_idx[0]}};
      end
      (pat_q == 2'd1): begin
        pr_c = {8{grid_c}};
        pg_c = {8{grid_c}};
        pb_c = {8{grid_c}};
      end
      (pat_q == 2'd2): begin
        pr_c   = x_q[7:0];
        pg_c   = y_q[7:0];
        ramp_c = 1'b1;
      end
      default: ext_c = 1'b1;
    endcase
  end

  // stage 1 pattern fields
  always_ff @(posedge pixclk) begin
    if (reset) begin
      s1_ext  <= 1'b0;
      s1_ramp <= 1'b0;
      s1_r    <= '0;
      s1_g    <= '0;
      s1_b    <= '0;
    end else if (vif.enable) begin
      s1_ext  <= ext_c;
      s1_ramp <= ramp_c;
      s1_r    <= pr_c;
      s1_g    <= pg_c;
      s1_b    <= pb_c;
    end
  end
`else
  logic sel_unused;
  assign sel_unused = ^vif.pattern_sel;
`endif

  // stage 1: coordinate-derived timing flags
  always_ff @(posedge pixclk) begin
    if (reset) begin
      s1_act   <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
    end else if (vif.enable) begin
      s1_act   <= act_c;
      s1_hs    <= hs_c;
      s1_vs    <= vs_c;
      s1_first <= first_c;
    end
  end

  assign fc_nxt = s1_first ? fc_q + 16'd1 : fc_q;

  // stage 2: aligned timing, colour and frame counter
  always_ff @(posedge pixclk) begin
    if (reset) begin
      de_q <= 1'b0;
      hs_q <= ~H_POL;
      vs_q <= ~V_POL;
      fs_q <= 1'b0;
      fc_q <= '0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (vif.enable) begin
      de_q <= s1_act;
      hs_q <= s1_hs ? H_POL : ~H_POL;
      vs_q <= s1_vs ? V_POL : ~V_POL;
      fs_q <= s1_first;
      fc_q <= fc_nxt;
      if (!s1_act) begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
`ifdef VTG_TEST_PATTERN_EN
      end else if (!s1_ext) begin
        r_q <= s1_r;
        g_q <= s1_g;
        b_q <= s1_ramp ? fc_nxt[7:0] : s1_b;
`endif
      end else begin
        r_q <= vif.pix_r;
        g_q <= vif.pix_g;
        b_q <= vif.pix_b;
      end
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: scoreboard model of raster timing and
// colour, plus directed timing, pattern and stall scenarios.
`timescale 1ns/1ps
module tb_video_timing_gen;
  localparam int HA  = 40;
  localparam int HFP = 4;
  localparam int HS  = 6;
  localparam int HBP = 6;
  localparam int VA  = 36;
  localparam int VFP = 2;
  localparam int VS  = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int BW  = HA / 8;
  localparam bit HP  = 1'b1;
  localparam bit VP  = 1'b1;

  logic pixclk = 1'b0;
  logic reset  = 1'b1;
  logic pix_vary = 1'b0;
  int errors = 0;
  int checks = 0;

  video_timing_gen_if vif();

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(HP), .V_POL(VP)
  ) dut (
    .pixclk(pixclk),
    .reset(reset),
    .vif(vif)
  );

  always #5 pixclk = ~pixclk;

  typedef struct {
    bit act; bit hs; bit vs; bit first;
    bit ext; bit ramp;
    logic [7:0] r; logic [7:0] g; logic [7:0] b;
  } rec_t;

  rec_t q[$];
  int mx, my;
  logic [1:0] mpat;
  logic [15:0] mfc;
  logic e_de, e_hs, e_vs, e_fs;
  logic [7:0] e_r, e_g, e_b;

  function automatic rec_t make_rec(int cx, int cy, logic [1:0] p);
    rec_t r;
    logic [23:0] c;
    r = '{default: '0};
    r.act = (cx < HA) && (cy < VA);
    r.hs = (cx >= HA + HFP) && (cx < HA + HFP + HS);
    r.vs = (cy >= VA + VFP) && (cy < VA + VFP + VS);
    r.first = (cx == 0) && (cy == 0);
    c = '0;
`ifdef VTG_TEST_PATTERN_EN
    case (p)
      2'd0: begin
        case (cx / BW)
          0: c = 24'hFFFFFF;
          1: c = 24'hFFFF00;
          2: c = 24'h00FFFF;
          3: c = 24'h00FF00;
          4: c = 24'hFF00FF;
          5: c = 24'hFF0000;
          6: c = 24'h0000FF;
          default: c = 24'h000000;
        endcase
      end
      2'd1: c = ((cx % 32 == 0) || (cy % 32 == 0)) ? 24'hFFFFFF : 24'h0;
      2'd2: begin
        c = {8'(cx), 8'(cy), 8'h00};
        r.ramp = 1'b1;
      end
      default: r.ext = 1'b1;
    endcase
`else
    r.ext = 1'b1;
    if (p == 2'd3) c = '0;
`endif
    {r.r, r.g, r.b} = c;
    return r;
  endfunction

  function automatic logic [64:0] sample();
    return {vif.x, vif.y, vif.pix_req, vif.de, vif.hsync,
            vif.vsync, vif.frame_start, vif.frame_cnt,
            vif.red, vif.green, vif.blue};
  endfunction

  // scoreboard: push a record per advancing edge, pop the one due now
  always @(negedge pixclk) begin
    rec_t r;
    logic [64:0] got, want;
    logic req;
    if (reset) begin
      mx = 0; my = 0; mpat = '0; mfc = '0;
      q.delete();
      q.push_back('{default: '0});
      e_de = 1'b0; e_hs = ~HP; e_vs = ~VP; e_fs = 1'b0;
      e_r = '0; e_g = '0; e_b = '0;
    end else if (vif.enable) begin
      q.push_back(make_rec(mx, my, mpat));
      if (mx == HT - 1 && my == VT - 1) mpat = vif.pattern_sel;
      if (mx == HT - 1) begin
        mx = 0;
        my = (my == VT - 1) ? 0 : my + 1;
      end else begin
        mx = mx + 1;
      end
      r = q.pop_front();
      if (r.first) mfc = mfc + 16'd1;
      e_de = r.act;
      e_hs = r.hs ? HP : ~HP;
      e_vs = r.vs ? VP : ~VP;
      e_fs = r.first;
      if (!r.act) {e_r, e_g, e_b} = '0;
      else if (r.ext) {e_r, e_g, e_b} = {vif.pix_r, vif.pix_g, vif.pix_b};
      else {e_r, e_g, e_b} = {r.r, r.g, r.ramp ? mfc[7:0] : r.b};
    end
    req = (mx < HA) && (my < VA);
    want = {10'(mx), 10'(my), req, e_de, e_hs, e_vs, e_fs,
            mfc, e_r, e_g, e_b};
    got = sample();
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL scoreboard t=%0t got=%h want=%h", $time, got, want);
    end
  end

  // external pixel source: fixed colour or per-cycle random data
  initial begin
    vif.pix_r = 8'hA5; vif.pix_g = 8'h5A; vif.pix_b = 8'h3C;
    forever begin
      @(negedge pixclk); #1;
      if (pix_vary) begin
        vif.pix_r = 8'($urandom);
        vif.pix_g = 8'($urandom);
        vif.pix_b = 8'($urandom);
      end else begin
        vif.pix_r = 8'hA5; vif.pix_g = 8'h5A; vif.pix_b = 8'h3C;
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge pixclk);
  endtask

  task automatic wait_fs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < HT * VT + 8; i++) begin
      @(negedge pixclk);
      if (vif.frame_start === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_fs timeout got=0 want=1");
    end
  endtask

  task automatic test_reset();
    @(negedge pixclk); #1 reset = 1'b1; vif.enable = 1'b1;
    tick(5);
    checks++;
    if ({vif.de, vif.hsync, vif.vsync, vif.frame_start} !== 4'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b want=0000",
               {vif.de, vif.hsync, vif.vsync, vif.frame_start});
    end
    checks++;
    if ({vif.red, vif.green, vif.blue} !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb got=%h want=0",
               {vif.red, vif.green, vif.blue});
    end
    checks++;
    if ({vif.x, vif.y, vif.frame_cnt} !== 36'h0) begin
      errors++;
      $display("FAIL reset_xy_cnt got=%h want=0",
               {vif.x, vif.y, vif.frame_cnt});
    end
    #1 reset = 1'b0;
    tick(1);
    checks++;
    if (vif.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_fs_early got=%b want=0", vif.frame_start);
    end
    tick(1);
    checks++;
    if ({vif.frame_start, vif.frame_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL reset_fs_first got=%b/%0d want=1/1",
               vif.frame_start, vif.frame_cnt);
    end
  endtask

  task automatic test_h_timing();
    int n, run, len, per, bad;
    bit seen_low;
    logic pr1, pr2;
    @(negedge pixclk); #1 reset = 1'b1;
    @(negedge pixclk); #1 reset = 1'b0;
    n = -1;
    for (int i = 1; i <= 2 * HT; i++) begin
      @(negedge pixclk);
      if (vif.hsync === HP) begin n = i; break; end
    end
    checks++;
    if (n != HA + HFP + 2) begin
      errors++;
      $display("FAIL hsync_first got=%0d want=%0d", n, HA + HFP + 2);
    end
    run = 1;
    for (int i = 0; i < 2 * HT; i++) begin
      @(negedge pixclk);
      if (vif.hsync === HP) run++;
      else break;
    end
    checks++;
    if (run != HS) begin
      errors++;
      $display("FAIL hsync_width got=%0d want=%0d", run, HS);
    end
    for (int i = 0; i < 2 * HT; i++) begin
      @(negedge pixclk);
      if (vif.de === 1'b1) break;
    end
    len = 1; per = 0; seen_low = 1'b0;
    for (int i = 0; i < 3 * HT; i++) begin
      @(negedge pixclk);
      per++;
      if (vif.de !== 1'b1) seen_low = 1'b1;
      else if (!seen_low) len++;
      else break;
    end
    checks++;
    if (len != HA || per != HT) begin
      errors++;
      $display("FAIL de_line got=%0d/%0d want=%0d/%0d", len, per, HA, HT);
    end
    pr2 = vif.pix_req;
    @(negedge pixclk);
    pr1 = vif.pix_req;
    bad = 0;
    for (int i = 0; i < 3 * HT; i++) begin
      @(negedge pixclk);
      if (vif.de !== pr2) bad++;
      pr2 = pr1;
      pr1 = vif.pix_req;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pix_req_lead got=%0d want=0 misaligned", bad);
    end
  endtask

  task automatic test_frame();
    int vs_b, vs_e, per;
    bit ok;
    @(negedge pixclk); #1 reset = 1'b1;
    @(negedge pixclk); #1 reset = 1'b0;
    wait_fs(ok);
    vs_b = -1; vs_e = -1; per = -1;
    for (int i = 1; i <= HT * VT + 8; i++) begin
      @(negedge pixclk);
      if (vs_b < 0 && vif.vsync === VP) vs_b = i;
      if (vs_b >= 0 && vs_e < 0 && vif.vsync !== VP) vs_e = i;
      if (vif.frame_start === 1'b1) begin per = i; break; end
    end
    checks++;
    if (vs_b != (VA + VFP) * HT) begin
      errors++;
      $display("FAIL vsync_start got=%0d want=%0d", vs_b, (VA + VFP) * HT);
    end
    checks++;
    if (vs_e - vs_b != VS * HT) begin
      errors++;
      $display("FAIL vsync_width got=%0d want=%0d", vs_e - vs_b, VS * HT);
    end
    checks++;
    if (per != HT * VT) begin
      errors++;
      $display("FAIL fs_period got=%0d want=%0d", per, HT * VT);
    end
    wait_fs(ok);
    checks++;
    if (vif.frame_cnt !== 16'd3) begin
      errors++;
      $display("FAIL frame_cnt3 got=%0d want=3", vif.frame_cnt);
    end
  endtask

  task automatic test_bars();
    bit ok;
    logic [23:0] c;
    logic [23:0] w0, w1, w6, w7;
`ifdef VTG_TEST_PATTERN_EN
    w0 = 24'hFFFFFF; w1 = 24'hFFFF00; w6 = 24'h0000FF; w7 = 24'h000000;
`else
    w0 = 24'hA55A3C; w1 = 24'hA55A3C; w6 = 24'hA55A3C; w7 = 24'hA55A3C;
`endif
    wait_fs(ok);
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if (c !== w0) begin
      errors++;
      $display("FAIL bar_x0 got=%h want=%h", c, w0);
    end
    for (int k = 1; k <= HA; k++) begin
      @(negedge pixclk);
      c = {vif.red, vif.green, vif.blue};
      if (k == BW) begin
        checks++;
        if (c !== w1) begin
          errors++;
          $display("FAIL bar_yellow got=%h want=%h", c, w1);
        end
      end
      if (k == 7 * BW - 1) begin
        checks++;
        if (c !== w6) begin
          errors++;
          $display("FAIL bar_blue got=%h want=%h", c, w6);
        end
      end
      if (k == HA - 1) begin
        checks++;
        if ({vif.de, c} !== {1'b1, w7}) begin
          errors++;
          $display("FAIL bar_last got=%h want=%h", {vif.de, c}, {1'b1, w7});
        end
      end
      if (k == HA) begin
        checks++;
        if ({vif.de, c} !== 25'h0) begin
          errors++;
          $display("FAIL bar_blank got=%h want=0", {vif.de, c});
        end
      end
    end
  endtask

  task automatic test_switch();
    bit ok;
    logic [23:0] c, w;
    pix_vary = 1'b0;
    wait_fs(ok);
    tick(HT * (VA / 2));
    #1 vif.pattern_sel = 2'd3;
    tick(HT);
`ifdef VTG_TEST_PATTERN_EN
    w = 24'hFFFFFF;
`else
    w = 24'hA55A3C;
`endif
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if (c !== w) begin
      errors++;
      $display("FAIL switch_hold got=%h want=%h", c, w);
    end
    wait_fs(ok);
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if ({vif.de, c} !== {1'b1, 24'hA55A3C}) begin
      errors++;
      $display("FAIL switch_ext got=%h want=1a55a3c", {vif.de, c});
    end
    #1 pix_vary = 1'b1;
    wait_fs(ok);
    #1 pix_vary = 1'b0;
  endtask

  task automatic test_grid();
    bit ok;
    logic [23:0] c, wh, bk;
    #1 vif.pattern_sel = 2'd1;
    wait_fs(ok);
    wait_fs(ok);
`ifdef VTG_TEST_PATTERN_EN
    wh = 24'hFFFFFF; bk = 24'h000000;
`else
    wh = 24'hA55A3C; bk = 24'hA55A3C;
`endif
    tick(HT);
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if (c !== wh) begin
      errors++;
      $display("FAIL grid_line got=%h want=%h", c, wh);
    end
    tick(1);
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if (c !== bk) begin
      errors++;
      $display("FAIL grid_cell got=%h want=%h", c, bk);
    end
  endtask

  task automatic test_ramp();
    bit ok;
    logic [23:0] c, w;
    #1 vif.pattern_sel = 2'd2;
    wait_fs(ok);
    wait_fs(ok);
    tick(HT + 3);
    #2;
`ifdef VTG_TEST_PATTERN_EN
    w = {8'd3, 8'd1, mfc[7:0]};
`else
    w = 24'hA55A3C;
`endif
    c = {vif.red, vif.green, vif.blue};
    checks++;
    if (c !== w) begin
      errors++;
      $display("FAIL ramp_px got=%h want=%h", c, w);
    end
  endtask

  task automatic test_stall();
    bit ok;
    int n, bad;
    logic [64:0] snap;
    #1 vif.pattern_sel = 2'd3;
    pix_vary = 1'b1;
    wait_fs(ok);
    tick(10);
    snap = sample();
    #1 vif.enable = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pixclk);
      if (sample() !== snap) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_frozen got=%0d want=0 changes", bad);
    end
    #1 vif.enable = 1'b1;
    n = -1;
    for (int i = 31; i <= 30 + 2 * HT; i++) begin
      @(negedge pixclk);
      if (vif.hsync === HP) begin n = i; break; end
    end
    checks++;
    if (n != HA + HFP + 20) begin
      errors++;
      $display("FAIL stall_shift got=%0d want=%0d", n, HA + HFP + 20);
    end
    #1 pix_vary = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_fs(ok);
    tick(HT * 3 + 7);
    #1 reset = 1'b1; vif.enable = 1'b0;
    tick(1);
    checks++;
    if ({vif.x, vif.y} !== 20'h0) begin
      errors++;
      $display("FAIL mid_reset_xy got=%h want=0", {vif.x, vif.y});
    end
    #1 reset = 1'b0; vif.enable = 1'b1;
    tick(2);
    checks++;
    if ({vif.frame_start, vif.frame_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL mid_reset_fs got=%b/%0d want=1/1",
               vif.frame_start, vif.frame_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vif.enable = 1'b1;
    vif.pattern_sel = 2'd0;
    test_reset();
    test_h_timing();
    test_frame();
    test_bars();
    test_switch();
    test_grid();
    test_ramp();
    test_stall();
    test_reset_mid();
    tick(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
